// File: rtl/single_divide.sv
// Iterative IEEE-754 single-precision divider, c = a / b, radix-2 restoring
// mantissa division with fixed latency for every operand class.
module single_divide (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_NAN  = 2'd1,
        SPC_INF  = 2'd2,
        SPC_ZERO = 2'd3
    } spc_t;

    state_t             state_r;
    spc_t               spc_r;
    logic [4:0]         cnt_r;
    logic               phase_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        mb_r;
    logic [25:0]        rem_r;
    logic [26:0]        q_r;
    logic [23:0]        mant_r;
    logic               guard_r;
    logic               sticky_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [31:0]        c_r;

    logic               zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s;
    spc_t               spc_s;
    logic signed [9:0]  exp_in_s;
    logic               ge_s;
    logic [25:0]        rem_sub_s;
    logic [23:0]        norm_mant_s;
    logic               norm_guard_s;
    logic               norm_sticky_s;
    logic signed [9:0]  norm_exp_s;
    logic               round_up_s;
    logic [24:0]        mant_rnd_s;
    logic [22:0]        mant_fin_s;
    logic signed [9:0]  exp_fin_s;
    logic [31:0]        result_s;

    assign zero_a_s = (a[30:23] == 8'd0);
    assign zero_b_s = (b[30:23] == 8'd0);
    assign inf_a_s  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign inf_b_s  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign nan_a_s  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign nan_b_s  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign exp_in_s = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;

    // Operand class decode; subnormal inputs are already flushed via zero_*
    always_comb begin
        spc_s = SPC_NONE;
        if (nan_a_s || nan_b_s || (zero_a_s && zero_b_s) || (inf_a_s && inf_b_s)) begin
            spc_s = SPC_NAN;
        end else if ((zero_b_s && !zero_a_s) || (inf_a_s && !inf_b_s)) begin
            spc_s = SPC_INF;
        end else if ((zero_a_s && !zero_b_s) || (inf_b_s && !inf_a_s)) begin
            spc_s = SPC_ZERO;
        end else begin
            spc_s = SPC_NONE;
        end
    end

    // One restoring-division step
    assign ge_s      = (rem_r >= {2'b00, mb_r});
    assign rem_sub_s = ge_s ? (rem_r - {2'b00, mb_r}) : rem_r;

    // Normalise the 27-bit quotient to a 24-bit mantissa plus guard/sticky
    always_comb begin
        norm_mant_s   = 24'd0;
        norm_guard_s  = 1'b0;
        norm_sticky_s = 1'b0;
        norm_exp_s    = exp_r;
        if (q_r[26]) begin
            norm_mant_s   = q_r[26:3];
            norm_guard_s  = q_r[2];
            norm_sticky_s = (|q_r[1:0]) | (|rem_r);
            norm_exp_s    = exp_r;
        end else begin
            norm_mant_s   = q_r[25:2];
            norm_guard_s  = q_r[1];
            norm_sticky_s = q_r[0] | (|rem_r);
            norm_exp_s    = exp_r - 10'sd1;
        end
    end

    // Round to nearest even; a carry out of the mantissa bumps the exponent
    always_comb begin
        round_up_s = guard_r & (sticky_r | mant_r[0]);
        mant_rnd_s = {1'b0, mant_r} + {24'd0, round_up_s};
        mant_fin_s = 23'd0;
        exp_fin_s  = exp_r;
        if (mant_rnd_s[24]) begin
            mant_fin_s = mant_rnd_s[23:1];
            exp_fin_s  = exp_r + 10'sd1;
        end else begin
            mant_fin_s = mant_rnd_s[22:0];
            exp_fin_s  = exp_r;
        end
    end

    // Final packing with overflow/underflow and special-class override
    always_comb begin
        result_s = 32'd0;
        case (spc_r)
            SPC_NAN:  result_s = 32'h7FC0_0000;
            SPC_INF:  result_s = {sign_r, 8'hFF, 23'd0};
            SPC_ZERO: result_s = {sign_r, 31'd0};
            SPC_NONE: begin
                if (exp_fin_s >= 10'sd255) begin
                    result_s = {sign_r, 8'hFF, 23'd0};
                end else if (exp_fin_s <= 10'sd0) begin
                    result_s = {sign_r, 31'd0};
                end else begin
                    result_s = {sign_r, exp_fin_s[7:0], mant_fin_s};
                end
            end
            default:  result_s = 32'd0;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            spc_r       <= SPC_NONE;
            cnt_r       <= 5'd0;
            phase_r     <= 1'b0;
            sign_r      <= 1'b0;
            exp_r       <= 10'sd0;
            mb_r        <= 24'd0;
            rem_r       <= 26'd0;
            q_r         <= 27'd0;
            mant_r      <= 24'd0;
            guard_r     <= 1'b0;
            sticky_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            c_r         <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sign_r     <= a[31] ^ b[31];
                        exp_r      <= exp_in_s;
                        rem_r      <= {2'b01, a[22:0]};
                        mb_r       <= {1'b1, b[22:0]};
                        q_r        <= 27'd0;
                        spc_r      <= spc_s;
                        cnt_r      <= 5'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= DIV;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                DIV: begin
                    q_r   <= {q_r[25:0], ge_s};
                    rem_r <= {rem_sub_s[24:0], 1'b0};
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd26) begin
                        phase_r <= 1'b0;
                        state_r <= NORM;
                    end else begin
                        state_r <= DIV;
                    end
                end
                NORM: begin
                    // First NORM edge normalises, second rounds and loads c
                    if (!phase_r) begin
                        mant_r   <= norm_mant_s;
                        guard_r  <= norm_guard_s;
                        sticky_r <= norm_sticky_s;
                        exp_r    <= norm_exp_s;
                        phase_r  <= 1'b1;
                    end else begin
                        c_r         <= result_s;
                        out_valid_r <= 1'b1;
                        phase_r     <= 1'b0;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        cnt_r       <= 5'd0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign c         = c_r;

endmodule

// File: tb/tb_single_divide.sv
// Scoreboard bench for single_divide: expected quotients queued at accept,
// popped and compared at each output handshake, with latency checks.
module tb_single_divide;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    bit          seen_valid = 1'b0;
    logic [31:0] exp_q[$];

    single_divide dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Output monitor: latency on first valid cycle, result on each handshake
    always @(negedge clk) begin
        if (out_valid === 1'b1 && !seen_valid) begin
            seen_valid = 1'b1;
            check("latency", 32'(cyc - accept_cyc), 32'd29);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            seen_valid = 1'b0;
            if (exp_q.size() == 0) begin
                check("extra_result", 32'(exp_q.size()), 32'd1);
            end else begin
                check("result", c, exp_q.pop_front());
            end
        end
    end

    task automatic start(input logic [31:0] ta, input logic [31:0] tbv, input logic [31:0] want);
        int n = 0;
        @(negedge clk);
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        exp_q.push_back(want);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run(input logic [31:0] ta, input logic [31:0] tbv, input logic [31:0] want);
        start(ta, tbv, want);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 32'd0;
        b = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_c", c, 32'd0);

        // Normal quotients and rounding
        run(32'h40A0_0000, 32'h3F80_0000, 32'h40A0_0000);
        run(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
        run(32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB);
        run(32'hC874_2400, 32'h43FA_0000, 32'hC3FA_0000);
        run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);

        // Special operand classes
        run(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
        run(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000);
        run(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
        run(32'h0000_0000, 32'h40A0_0000, 32'h0000_0000);
        run(32'h40A0_0000, 32'h7F80_0000, 32'h0000_0000);
        run(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
        run(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);
        run(32'hFF80_0000, 32'h4000_0000, 32'h7F80_0000 | 32'h8000_0000);

        // Exponent range limits
        run(32'h7E96_7699, 32'h3A83_126F, 32'h7F80_0000);
        run(32'h0DA2_4260, 32'h7149_F2CA, 32'h0000_0000);
        run(32'h8DA2_4260, 32'h7149_F2CA, 32'h8000_0000);

        // Back-pressure and ignored in_valid while busy
        out_ready = 1'b0;
        start(32'h40A0_0000, 32'h3F80_0000, 32'h40A0_0000);
        n = 0;
        a = 32'h40C0_0000;
        b = 32'h4000_0000;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            in_valid = n[0];
            n++;
        end
        if (out_valid !== 1'b1) check("valid_timeout", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_c", c, 32'h40A0_0000);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            in_valid = ~in_valid;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        run(32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB);

        // Abort mid-division
        start(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_c", c, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
